// File: rtl/display_scan_pkg.sv
// Shared types and helpers for the multiplexed seven-segment digit scanner.
package display_scan_pkg;

    typedef enum logic {SCAN_SHOW, SCAN_BLANK} scan_state_t;

    // Widest digit count the onehot_n helper can describe.
    localparam int MAX_DIGITS = 32;

    // Active-low one-hot vector: bit idx low, everything else high.
    // An index at or beyond n yields all ones (nothing enabled).
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input int idx, input int n);
        logic [MAX_DIGITS-1:0] r;
        r = '1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i == idx && i < n) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A load value of N-1 gives a dwell of exactly N cycles before the next load.
module scan_timer #(
    parameter int            W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            cnt <= RST_VAL;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexes NUM_DIGITS packed digit values onto one segment decoder
// input, with active-low one-hot digit enables and a blanking gap between
// digits to suppress ghosting.
// Optional build macro: DISPLAY_SCAN_ZERO_SUPPRESS_EN (leading-zero blanking).
module display_scan_mux
    import display_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int DIGIT_W    = 4,
    parameter int DIV_CNT    = 24000,
    parameter int BLANK_CNT  = 240
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic [DIGIT_W-1:0]            s,
    output logic [NUM_DIGITS-1:0]         en_n,
    output logic [$clog2(NUM_DIGITS)-1:0] sel,
    output logic                          frame_tick
);

    localparam int IW      = $clog2(NUM_DIGITS);
    // A zero-length blank still costs one cycle (the post-reset blank).
    localparam int BLANK_P = (BLANK_CNT > 0) ? BLANK_CNT : 1;
    localparam int MAXP    = (DIV_CNT > BLANK_P) ? DIV_CNT : BLANK_P;
    localparam int TW      = $clog2(MAXP + 1);
    localparam logic [TW-1:0] DIV_LD   = TW'(DIV_CNT - 1);
    localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_P - 1);
    localparam logic [IW-1:0] LAST    = IW'(NUM_DIGITS - 1);

    scan_state_t          state, state_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic                 ft_nxt;
    logic                 tmr_load, tmr_tc;
    logic [TW-1:0]        tmr_val;
    logic [DIGIT_W-1:0]   dig [NUM_DIGITS];
    logic [MAX_DIGITS-1:0] oh_full;
    logic                 suppress;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            assign dig[g] = digits[g*DIGIT_W +: DIGIT_W];
        end
        if (NUM_DIGITS < MAX_DIGITS) begin : g_sink
            logic unused_oh;
            assign unused_oh = ^oh_full[MAX_DIGITS-1:NUM_DIGITS];
        end
    endgenerate

    scan_timer #(.W(TW), .RST_VAL(BLANK_LD)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // State, index and frame pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCAN_BLANK;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            frame_tick <= ft_nxt;
        end
    end

    // Next-state: the index advances at the end of SHOW so s settles during the blank.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ft_nxt    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (tmr_tc) begin
            tmr_load = 1'b1;
            case (state)
                SCAN_SHOW: begin
                    idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;
                    ft_nxt  = (idx == LAST);
                    if (BLANK_CNT > 0) begin
                        state_nxt = SCAN_BLANK;
                        tmr_val   = BLANK_LD;
                    end else begin
                        state_nxt = SCAN_SHOW;
                        tmr_val   = DIV_LD;
                    end
                end
                default: begin
                    state_nxt = SCAN_SHOW;
                    tmr_val   = DIV_LD;
                end
            endcase
        end
    end

`ifdef DISPLAY_SCAN_ZERO_SUPPRESS_EN
    // Blank digit idx>0 when it and every more significant digit are zero.
    always_comb begin
        logic hi_nz;
        hi_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && dig[i] != '0) hi_nz = 1'b1;
        end
        suppress = (idx != '0) && !hi_nz;
    end
`else
    assign suppress = 1'b0;
`endif

    // Enables depend only on registered state/idx, so digits never glitch them.
    always_comb begin
        oh_full = onehot_n(int'(idx), NUM_DIGITS);
        if (state == SCAN_SHOW && !suppress) en_n = oh_full[NUM_DIGITS-1:0];
        else                                 en_n = '1;
    end

    assign s   = dig[idx];
    assign sel = idx;

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised, self-timed successor to the 2:1 display-value mux.
- Time-multiplexes NUM_DIGITS packed digit values onto one shared seven-segment decoder input.
- Drives active-low one-hot digit enables, with a programmable blanking gap between digits to suppress ghosting.
- Sits between the value sources (switches, counters) and the segment decoder/anode pins.

Parameters:
- NUM_DIGITS, 2, number of scanned digits; >=2.
- DIGIT_W, 4, bits per digit value.
- DIV_CNT, 24000, clk cycles each digit is enabled; >=1.
- BLANK_CNT, 240, clk cycles all enables are off between digits; >=0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits  in  NUM_DIGITS*DIGIT_W  packed values; digit i = digits[i*DIGIT_W +: DIGIT_W].
- s  out  DIGIT_W  selected digit value to the segment decoder.
- en_n  out  NUM_DIGITS  active-low one-hot digit enables.
- sel  out  $clog2(NUM_DIGITS)  current digit index.
- frame_tick  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Registers:
  - state: SCAN_SHOW or SCAN_BLANK.
  - idx: current digit index.
  - cnt: dwell counter.
  - frame_tick: registered pulse.
- Reset value of every output:
  - state=SCAN_BLANK, idx=0, cnt=0.
  - en_n = all ones, sel = 0, frame_tick = 0.
  - s = digit 0.
  - Reset is forced asynchronously on assertion.
- Outputs:
  - s is combinational from digits and idx: zero latency from digits to s.
  - sel = idx.
  - en_n is decoded from registered state/idx only, with no path from digits. In SHOW, bit idx = 0 and all other bits = 1; in BLANK, all ones.
- SCAN_SHOW:
  - cnt counts 0..DIV_CNT-1.
  - At cnt==DIV_CNT-1: idx advances (NUM_DIGITS-1 wraps to 0) and cnt=0.
  - Next state is SCAN_BLANK if BLANK_CNT>0, else SCAN_SHOW.
- SCAN_BLANK:
  - cnt counts 0..max(BLANK_CNT,1)-1; at the last count, state=SCAN_SHOW and cnt=0.
  - The index has already advanced, so s settles to the next digit while en_n is off.
- Timing:
  - Digit slot = DIV_CNT+BLANK_CNT cycles.
  - Frame = NUM_DIGITS*(DIV_CNT+BLANK_CNT) cycles.
  - After reset release: one blank period (1 cycle if BLANK_CNT==0), then digit 0.
- frame_tick:
  - High for exactly one cycle, in the first cycle idx holds 0 after a wrap from NUM_DIGITS-1.
  - Never pulses on the post-reset start.
- Boundary conditions:
  - digits changing mid-slot: s follows immediately; timing and en_n are unaffected.
  - Reset mid-slot: en_n goes all ones within the same cycle (async); scan restarts at digit 0.
  - NUM_DIGITS not a power of two: idx never exceeds NUM_DIGITS-1.
  - BLANK_CNT==0: BLANK state is entered only out of reset.

Optional Feature:
- Macro: DISPLAY_SCAN_ZERO_SUPPRESS_EN.
- Defined (leading-zero suppression):
  - During a SHOW slot for idx>0, en_n stays all ones if digit idx and every higher digit are zero.
  - Slot timing, sel, s and frame_tick are unchanged.
  - Digit 0 is always shown.
- Undefined: every digit is enabled in its slot.

Decomposition:
- Package display_scan_pkg:
  - typedef enum logic {SCAN_SHOW, SCAN_BLANK} scan_state_t.
  - Function onehot_n(idx, n) returning the active-low one-hot vector.
- Sub-module scan_timer:
  - Parametrised down-counter with load value and terminal-count pulse.
  - Instantiated once; the FSM reloads it with DIV_CNT or BLANK_CNT.

Test Plan:
Benches use NUM_DIGITS=2, DIGIT_W=4, DIV_CNT=4, BLANK_CNT=1, with checks sampled each clk edge.

1. reset=1 with digits=8'hA5 -> en_n=2'b11, sel=0, s=4'h5, frame_tick=0.
2. Release reset, digits=8'hA5 -> sequence below, then 10-cycle period repeating:
   - 1 cycle en_n=11.
   - 4 cycles en_n=10, s=5.
   - 1 cycle en_n=11, s=A.
   - 4 cycles en_n=01, s=A.
   - 1 cycle en_n=11, s=5, frame_tick=1 (only that cycle).
3. Change digits 8'hA5 -> 8'h3C in the 2nd cycle of the digit-0 slot -> s=C in that same cycle; en_n stays 10 through the remaining cycles of the 4-cycle slot.
4. Assert reset during an en_n=01 cycle -> en_n=11 and sel=0 before the next edge. After release, the step 2 sequence restarts from its first blank cycle.
5. NUM_DIGITS=3, BLANK_CNT=0, digits=12'h321 -> after the 1 reset-blank cycle, en_n=110/101/011 with s=1/2/3 for 4 cycles each; frame_tick every 12 cycles; en_n never 111 again.
6. With DISPLAY_SCAN_ZERO_SUPPRESS_EN defined:
   - digits=8'h05 -> digit-1 slot shows en_n=11 while sel=1.
   - digits=8'h00 -> digit-0 slot shows en_n=10, s=0.
   - Without the macro, digits=8'h05 -> digit-1 slot shows en_n=01.
